// File: rtl/vga_plot_arbiter.sv
// Sole writer of the vga_adapter pixel port. Round-robin arbitration among single-pixel
// clients, plus a rectangle-fill engine that takes over the port while it runs.
module vga_plot_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int X_MAX   = 159,
   parameter int Y_MAX   = 119
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_x,
   input  logic [7*NUM_REQ-1:0]   req_y,
   input  logic [3*NUM_REQ-1:0]   req_colour,
   output logic [NUM_REQ-1:0]     gnt,
   input  logic                   fill_start,
   input  logic [7:0]             fill_x0,
   input  logic [6:0]             fill_y0,
   input  logic [7:0]             fill_w,
   input  logic [6:0]             fill_h,
   input  logic [2:0]             fill_colour,
   output logic                   fill_busy,
   output logic                   fill_done,
   output logic [7:0]             x,
   output logic [6:0]             y,
   output logic [2:0]             colour,
   output logic                   plot
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, FILL} state_t;

   state_t             state, state_n;
   logic [PTR_W-1:0]   ptr, ptr_n;
   logic [PTR_W-1:0]   winner;
   logic [PTR_W:0]     cand_sum;
   logic               found;
   logic [NUM_REQ-1:0] eligible;

   logic [7:0]         org_x;
   logic [8:0]         x_end, y_end;
   logic [2:0]         fill_col;
   logic               fill_empty;
   logic [7:0]         cur_x, cur_x_n;
   logic [6:0]         cur_y, cur_y_n;

   logic [7:0]         x_n;
   logic [6:0]         y_n;
   logic [2:0]         colour_n;
   logic               plot_n, busy_n, done_n;
   logic [NUM_REQ-1:0] gnt_n;

   logic               accept, last_pix, empty_calc;
   logic [8:0]         x_end_raw, y_end_raw, x_end_calc, y_end_calc;

   // A fill is only taken once the previous one has fully retired (busy low).
   assign accept     = (state == IDLE) && !fill_busy && fill_start;
   assign x_end_raw  = {1'b0, fill_x0} + {1'b0, fill_w} - 9'd1;
   assign y_end_raw  = {2'b0, fill_y0} + {2'b0, fill_h} - 9'd1;
   assign x_end_calc = (x_end_raw > 9'(X_MAX)) ? 9'(X_MAX) : x_end_raw;
   assign y_end_calc = (y_end_raw > 9'(Y_MAX)) ? 9'(Y_MAX) : y_end_raw;
   assign empty_calc = (fill_w == 8'd0) || (fill_h == 7'd0) ||
                       ({1'b0, fill_x0} > 9'(X_MAX)) || ({2'b0, fill_y0} > 9'(Y_MAX));
   assign last_pix   = ({1'b0, cur_x} == x_end) && ({2'b0, cur_y} == y_end);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         x          <= '0;
         y          <= '0;
         colour     <= '0;
         plot       <= 1'b0;
         gnt        <= '0;
         fill_busy  <= 1'b0;
         fill_done  <= 1'b0;
         cur_x      <= '0;
         cur_y      <= '0;
         org_x      <= '0;
         x_end      <= '0;
         y_end      <= '0;
         fill_col   <= '0;
         fill_empty <= 1'b0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         x         <= x_n;
         y         <= y_n;
         colour    <= colour_n;
         plot      <= plot_n;
         gnt       <= gnt_n;
         fill_busy <= busy_n;
         fill_done <= done_n;
         cur_x     <= cur_x_n;
         cur_y     <= cur_y_n;
         if (accept) begin
            org_x      <= fill_x0;
            x_end      <= x_end_calc;
            y_end      <= y_end_calc;
            fill_col   <= fill_colour;
            fill_empty <= empty_calc;
         end
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = FILL;
         FILL:    if (fill_empty || last_pix) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // A client is masked during its own grant cycle so a held req cannot win twice in a row.
   always_comb begin
      eligible = req & ~gnt;
      found    = 1'b0;
      winner   = '0;
      cand_sum = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (cand_sum >= (PTR_W+1)'(NUM_REQ))
            cand_sum = cand_sum - (PTR_W+1)'(NUM_REQ);
         if (!found && eligible[cand_sum[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = cand_sum[PTR_W-1:0];
         end
      end
   end

   always_comb begin
      x_n      = x;
      y_n      = y;
      colour_n = colour;
      plot_n   = 1'b0;
      gnt_n    = '0;
      busy_n   = fill_busy;
      done_n   = 1'b0;
      ptr_n    = ptr;
      cur_x_n  = cur_x;
      cur_y_n  = cur_y;
      case (state)
         IDLE: begin
            if (accept) begin
               busy_n  = 1'b1;
               cur_x_n = fill_x0;
               cur_y_n = fill_y0;
            end else begin
               busy_n = 1'b0;
               if (found) begin
                  plot_n = 1'b1;
                  ptr_n  = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                  for (int i = 0; i < NUM_REQ; i++) begin
                     if (PTR_W'(i) == winner) begin
                        x_n      = req_x[8*i +: 8];
                        y_n      = req_y[7*i +: 7];
                        colour_n = req_colour[3*i +: 3];
                        gnt_n[i] = 1'b1;
                     end
                  end
               end
            end
         end
         FILL: begin
            if (fill_empty) begin
               done_n = 1'b1;
            end else begin
               plot_n   = 1'b1;
               x_n      = cur_x;
               y_n      = cur_y;
               colour_n = fill_col;
               if (last_pix) begin
                  done_n = 1'b1;
               end else if ({1'b0, cur_x} == x_end) begin
                  cur_x_n = org_x;
                  cur_y_n = cur_y + 7'd1;
               end else begin
                  cur_x_n = cur_x + 8'd1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule
